// File: rtl/aes_inv_key_sched.sv
`default_nettype none
// ============================================================================
//  Module   : aes_inv_key_sched (with helper aes_sbox)
//  Purpose  : Sequential AES-128 key schedule for the decryption datapath.
//             A cipher key is expanded forward for NR cycles to reach round
//             key NR. The schedule is then walked backwards, and round keys
//             NR..0 are presented on a valid/ready stream. A key that is
//             already round key NR can be loaded directly, which skips the
//             expansion.
//  Ports    : clk, rst_n      - clock (rising edge), async active-low reset
//             start           - load request, honoured only when idle
//             key_in          - cipher key or round key NR (first byte in MSBs)
//             key_is_last     - 1: key_in is round key NR, skip expansion
//             busy            - engine not idle
//             out_valid/ready - round key stream handshake
//             out_key         - round key, words W0..W3 from MSB to LSB
//             out_round       - round index of out_key (NR down to 0)
//             done            - one-cycle pulse after round key 0 is taken
//  Revision : 1.0 - initial release
// ============================================================================

// ----------------------------------------------------------------------------
//  aes_sbox : AES forward S-box, computed as GF(2^8) inverse plus affine map
//             (combinational, one byte).
// ----------------------------------------------------------------------------
module aes_sbox (
   input  logic [7:0] din,
   output logic [7:0] dout
);

   function automatic logic [7:0] xtime(input logic [7:0] a);
      return {a[6:0], 1'b0} ^ (a[7] ? 8'h1b : 8'h00);
   endfunction

   function automatic logic [7:0] gf_mul(input logic [7:0] a, input logic [7:0] b);
      logic [7:0] acc;
      logic [7:0] x;
      acc = 8'h00;
      x   = a;
      for (int i = 0; i < 8; i++) begin
         if (b[i]) acc = acc ^ x;
         x = xtime(x);
      end
      return acc;
   endfunction

   // a^254 is the multiplicative inverse (0 maps to 0):
   // 254 = 2+4+8+16+32+64+128, accumulated while squaring.
   function automatic logic [7:0] gf_inv(input logic [7:0] a);
      logic [7:0] sq;
      logic [7:0] acc;
      sq  = a;
      acc = 8'h01;
      for (int i = 1; i < 8; i++) begin
         sq  = gf_mul(sq, sq);
         acc = gf_mul(acc, sq);
      end
      return acc;
   endfunction

   function automatic logic [7:0] rotl8(input logic [7:0] a, input int n);
      logic [15:0] d;
      d = {a, a} << n;
      return d[15:8];
   endfunction

   logic [7:0] inv_b;

   always_comb begin
      inv_b = gf_inv(din);
      dout  = inv_b ^ rotl8(inv_b, 1) ^ rotl8(inv_b, 2) ^
              rotl8(inv_b, 3) ^ rotl8(inv_b, 4) ^ 8'h63;
   end

endmodule

// ----------------------------------------------------------------------------
//  aes_inv_key_sched : top level
// ----------------------------------------------------------------------------
module aes_inv_key_sched #(
   parameter int NR = 10
) (
   input  logic         clk,
   input  logic         rst_n,
   input  logic         start,
   input  logic [127:0] key_in,
   input  logic         key_is_last,
   output logic         busy,
   output logic         out_valid,
   input  logic         out_ready,
   output logic [127:0] out_key,
   output logic [3:0]   out_round,
   output logic         done
);

   localparam logic [3:0] LAST_RND = 4'(NR);

   typedef enum logic [1:0] {
      ST_IDLE   = 2'd0,
      ST_EXPAND = 2'd1,
      ST_EMIT   = 2'd2
   } state_t;

   state_t        state_q, state_d;
   logic [127:0]  key_q, key_d;
   logic [3:0]    rnd_q, rnd_d;
   logic          valid_q;
   logic          done_q, done_d;

   // Datapath wires
   logic [31:0]   w0, w1, w2, w3;
   logic [31:0]   w3_inv;
   logic [31:0]   sbox_in;
   logic [31:0]   sub_word;
   logic [3:0]    rcon_idx;
   logic [31:0]   rcon_word;
   logic [127:0]  fwd_key;
   logic [127:0]  inv_key;
   logic [31:0]   fwd_t;
   logic [31:0]   fwd_w0, fwd_w1, fwd_w2, fwd_w3;

   function automatic logic [7:0] rcon_f(input logic [3:0] r);
      logic [7:0] rc;
      case (r)
         4'd1:    rc = 8'h01;
         4'd2:    rc = 8'h02;
         4'd3:    rc = 8'h04;
         4'd4:    rc = 8'h08;
         4'd5:    rc = 8'h10;
         4'd6:    rc = 8'h20;
         4'd7:    rc = 8'h40;
         4'd8:    rc = 8'h80;
         4'd9:    rc = 8'h1b;
         4'd10:   rc = 8'h36;
         default: rc = 8'h00;
      endcase
      return rc;
   endfunction

   function automatic logic [31:0] rot_word(input logic [31:0] w);
      return {w[23:0], w[31:24]};
   endfunction

   assign w0 = key_q[127:96];
   assign w1 = key_q[95:64];
   assign w2 = key_q[63:32];
   assign w3 = key_q[31:0];

   // In the inverse step the S-box sees the *new* W3 (W3 ^ W2), which is
   // already the previous round's W3; forward step uses the current W3.
   assign w3_inv   = w3 ^ w2;
   assign sbox_in  = (state_q == ST_EXPAND) ? rot_word(w3) : rot_word(w3_inv);

   // Forward step produces round rnd+1; inverse step consumes round rnd.
   assign rcon_idx  = (state_q == ST_EXPAND) ? (rnd_q + 4'd1) : rnd_q;
   assign rcon_word = {rcon_f(rcon_idx), 24'h000000};

   genvar gi;
   generate
      for (gi = 0; gi < 4; gi++) begin : g_sbox
         aes_sbox u_sbox (
            .din  (sbox_in[8*gi +: 8]),
            .dout (sub_word[8*gi +: 8])
         );
      end
   endgenerate

   // Forward expansion step
   assign fwd_t   = sub_word ^ rcon_word;
   assign fwd_w0  = w0 ^ fwd_t;
   assign fwd_w1  = w1 ^ fwd_w0;
   assign fwd_w2  = w2 ^ fwd_w1;
   assign fwd_w3  = w3 ^ fwd_w2;
   assign fwd_key = {fwd_w0, fwd_w1, fwd_w2, fwd_w3};

   // Inverse step: round r -> round r-1
   assign inv_key = {w0 ^ sub_word ^ rcon_word, w1 ^ w0, w2 ^ w1, w3_inv};

   always_comb begin
      state_d = state_q;
      key_d   = key_q;
      rnd_d   = rnd_q;
      done_d  = 1'b0;
      case (state_q)
         ST_IDLE: begin
            if (start) begin
               key_d = key_in;
               if (key_is_last) begin
                  rnd_d   = LAST_RND;
                  state_d = ST_EMIT;
               end else begin
                  rnd_d   = 4'd0;
                  state_d = ST_EXPAND;
               end
            end
         end
         ST_EXPAND: begin
            key_d = fwd_key;
            rnd_d = rnd_q + 4'd1;
            if ((rnd_q + 4'd1) == LAST_RND) state_d = ST_EMIT;
         end
         ST_EMIT: begin
            if (out_ready) begin
               if (rnd_q != 4'd0) begin
                  key_d = inv_key;
                  rnd_d = rnd_q - 4'd1;
               end else begin
                  state_d = ST_IDLE;
                  done_d  = 1'b1;
               end
            end
         end
         default: state_d = ST_IDLE;
      endcase
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q <= ST_IDLE;
         key_q   <= '0;
         rnd_q   <= 4'd0;
         valid_q <= 1'b0;
         done_q  <= 1'b0;
      end else begin
         state_q <= state_d;
         key_q   <= key_d;
         rnd_q   <= rnd_d;
         // Registered copy of "in EMIT" so out_valid comes straight off a flop.
         valid_q <= (state_d == ST_EMIT);
         done_q  <= done_d;
      end
   end

   assign busy      = (state_q != ST_IDLE);
   assign out_valid = valid_q;
   assign out_key   = key_q;
   assign out_round = rnd_q;
   assign done      = done_q;

endmodule
`default_nettype wire

// File: tb/tb_aes_inv_key_sched.sv
`default_nettype none
// ============================================================================
//  Module   : tb_aes_inv_key_sched
//  Purpose  : Self-checking bench for aes_inv_key_sched. Expected round keys
//             come from a textbook FIPS-197 word-array key expansion.
//  Revision : 1.0 - initial release
// ============================================================================
module tb_aes_inv_key_sched;

   logic         clk;
   logic         rst_n;
   logic         start;
   logic [127:0] key_in;
   logic         key_is_last;
   logic         busy;
   logic         out_valid;
   logic         out_ready;
   logic [127:0] out_key;
   logic [3:0]   out_round;
   logic         done;

   int n_checks;
   int n_fail;

   logic [7:0]   sbox_tab [0:255];
   logic [127:0] exp_rk   [0:10];

   localparam logic [127:0] FIPS_KEY = 128'h2b7e151628aed2a6abf7158809cf4f3c;

   aes_inv_key_sched #(.NR(10)) dut (
      .clk         (clk),
      .rst_n       (rst_n),
      .start       (start),
      .key_in      (key_in),
      .key_is_last (key_is_last),
      .busy        (busy),
      .out_valid   (out_valid),
      .out_ready   (out_ready),
      .out_key     (out_key),
      .out_round   (out_round),
      .done        (done)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic check_val(input string tag, input logic [127:0] got, input logic [127:0] exp);
      n_checks++;
      if (got !== exp) begin
         n_fail++;
         $display("FAIL %s: got %h expected %h", tag, got, exp);
      end
   endtask

   // S-box by the multiply-by-3 / divide-by-3 walk over the field.
   task automatic build_sbox();
      logic [7:0] p, q;
      p = 8'h01;
      q = 8'h01;
      for (int n = 0; n < 255; n++) begin
         p = p ^ {p[6:0], 1'b0} ^ (p[7] ? 8'h1b : 8'h00);
         q = q ^ {q[6:0], 1'b0};
         q = q ^ {q[5:0], 2'b00};
         q = q ^ {q[3:0], 4'h0};
         if (q[7]) q = q ^ 8'h09;
         sbox_tab[p] = q ^ {q[6:0], q[7]} ^ {q[5:0], q[7:6]} ^
                       {q[4:0], q[7:5]} ^ {q[3:0], q[7:4]} ^ 8'h63;
      end
      sbox_tab[0] = 8'h63;
   endtask

   // Plain FIPS-197 expansion into w[0..43]; round key r = w[4r..4r+3].
   task automatic build_schedule(input logic [127:0] key);
      logic [31:0] w [0:43];
      logic [31:0] t;
      logic [7:0]  rc;
      rc = 8'h01;
      for (int i = 0; i < 4; i++) w[i] = key[127-32*i -: 32];
      for (int i = 4; i < 44; i++) begin
         t = w[i-1];
         if (i % 4 == 0) begin
            t = {t[23:0], t[31:24]};
            t = {sbox_tab[t[31:24]], sbox_tab[t[23:16]], sbox_tab[t[15:8]], sbox_tab[t[7:0]]};
            t = t ^ {rc, 24'h0};
            rc = {rc[6:0], 1'b0} ^ (rc[7] ? 8'h1b : 8'h00);
         end
         w[i] = w[i-4] ^ t;
      end
      for (int r = 0; r <= 10; r++) exp_rk[r] = {w[4*r], w[4*r+1], w[4*r+2], w[4*r+3]};
   endtask

   function automatic logic [127:0] rand128();
      return {$urandom(), $urandom(), $urandom(), $urandom()};
   endfunction

   // Caller must be at a negedge; start is driven immediately, so chaining
   // a call directly after another lands start in the done cycle.
   task automatic run_seq(input logic [127:0] key, input bit is_last,
                          input int ready_pct, input bit inject);
      int lat;
      int idx;
      int guard;
      bit rdy;
      build_schedule(key);
      start       = 1'b1;
      key_in      = is_last ? exp_rk[10] : key;
      key_is_last = is_last;
      out_ready   = 1'b0;
      @(negedge clk);
      lat = 1;
      start = 1'b0;
      while (!out_valid && lat < 40) begin
         check_val("busy_expand", 128'(busy), 128'(1));
         if (inject) begin
            start       = 1'($urandom_range(0, 1));
            key_in      = rand128();
            key_is_last = 1'($urandom_range(0, 1));
         end
         out_ready = 1'($urandom_range(0, 1));
         @(negedge clk);
         lat++;
      end
      check_val("latency", 128'(lat), is_last ? 128'(1) : 128'(11));
      idx   = 10;
      guard = 0;
      while (idx >= 0 && guard < 400) begin
         check_val("valid", 128'(out_valid), 128'(1));
         check_val("busy", 128'(busy), 128'(1));
         check_val("done_low", 128'(done), 128'(0));
         check_val("round", 128'(out_round), 128'(idx));
         check_val("key", out_key, exp_rk[idx]);
         rdy = ($urandom_range(0, 99) < ready_pct);
         if (inject && $urandom_range(0, 2) == 0) begin
            start       = 1'b1;
            key_in      = rand128();
            key_is_last = 1'($urandom_range(0, 1));
         end else begin
            start = 1'b0;
         end
         out_ready = rdy;
         @(negedge clk);
         guard++;
         if (rdy) idx--;
      end
      if (idx >= 0) check_val("drain_timeout", 128'(idx), 128'hffffffff);
      out_ready = 1'b0;
      start     = 1'b0;
      check_val("done_pulse", 128'(done), 128'(1));
      check_val("busy_at_done", 128'(busy), 128'(0));
      check_val("valid_at_done", 128'(out_valid), 128'(0));
   endtask

   initial begin
      int guard;
      n_checks    = 0;
      n_fail      = 0;
      rst_n       = 1'b0;
      start       = 1'b0;
      key_in      = '0;
      key_is_last = 1'b0;
      out_ready   = 1'b0;
      build_sbox();

      #12;
      check_val("rst_busy", 128'(busy), 128'(0));
      check_val("rst_valid", 128'(out_valid), 128'(0));
      check_val("rst_key", out_key, 128'(0));
      check_val("rst_round", 128'(out_round), 128'(0));
      check_val("rst_done", 128'(done), 128'(0));
      @(negedge clk);
      rst_n = 1'b1;
      @(negedge clk);

      // Reference model against published vectors
      build_schedule(FIPS_KEY);
      check_val("model_rk10", exp_rk[10], 128'hd014f9a8c9ee2589e13f0cc8b6630ca6);
      check_val("model_rk9", exp_rk[9], 128'hac7766f319fadc2128d12941575c006e);
      check_val("model_rk1", exp_rk[1], 128'ha0fafe1788542cb123a339392a6c7605);

      // 1: forward expansion then full drain
      run_seq(FIPS_KEY, 1'b0, 100, 1'b0);
      @(negedge clk);
      // 2: direct load of round key 10
      run_seq(FIPS_KEY, 1'b1, 100, 1'b0);
      @(negedge clk);
      // 3: backpressure
      run_seq(FIPS_KEY, 1'b0, 50, 1'b0);
      @(negedge clk);
      // 4: spurious starts while busy, then a start in the done cycle
      run_seq(FIPS_KEY, 1'b0, 70, 1'b1);
      run_seq(rand128(), 1'b0, 100, 1'b0);
      run_seq(rand128(), 1'b1, 60, 1'b0);
      @(negedge clk);

      // 5: reset mid-emit at round 5
      start       = 1'b1;
      key_in      = FIPS_KEY;
      key_is_last = 1'b0;
      @(negedge clk);
      start     = 1'b0;
      out_ready = 1'b1;
      guard     = 0;
      while (!(out_valid && out_round == 4'd5) && guard < 60) begin
         @(negedge clk);
         guard++;
      end
      check_val("reach_round5", 128'(out_round), 128'(5));
      rst_n = 1'b0;
      #1;
      check_val("mid_rst_busy", 128'(busy), 128'(0));
      check_val("mid_rst_valid", 128'(out_valid), 128'(0));
      check_val("mid_rst_key", out_key, 128'(0));
      check_val("mid_rst_round", 128'(out_round), 128'(0));
      check_val("mid_rst_done", 128'(done), 128'(0));
      out_ready = 1'b0;
      @(negedge clk);
      check_val("rst_hold_valid", 128'(out_valid), 128'(0));
      rst_n = 1'b1;
      @(negedge clk);
      run_seq(FIPS_KEY, 1'b0, 100, 1'b0);
      @(negedge clk);

      // 6: all-zero key
      build_schedule(128'h0);
      check_val("model_zero_rk10", exp_rk[10], 128'hb4ef5bcb3e92e21123e951cf6f8f188e);
      run_seq(128'h0, 1'b0, 100, 1'b0);
      @(negedge clk);

      // Random keys, load modes and ready rates
      for (int n = 0; n < 8; n++) begin
         run_seq(rand128(), 1'($urandom_range(0, 1)), $urandom_range(30, 100),
                 1'($urandom_range(0, 1)));
         if ($urandom_range(0, 1) == 1) @(negedge clk);
      end

      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

endmodule
`default_nettype wire

// File: doc/aes_inv_key_sched.md
Name: aes_inv_key_sched

Overview:
Sequential AES-128 key schedule engine for the decryption datapath. It takes a 128-bit cipher key and runs the forward expansion for 10 cycles to reach round key 10. It then walks the schedule backwards, presenting round keys 10, 9, …, 0 one at a time on a valid/ready stream to the inverse-cipher round logic. A key already known to be round key 10 can be loaded directly, which skips the forward phase.

Parameters:
NR, 10, number of AES rounds; fixed at 10 for AES-128 (other values unsupported).

Ports:
clk         input   1    system clock, rising edge
rst_n       input   1    asynchronous active-low reset
start       input   1    load request; sampled only in IDLE
key_in      input   128  cipher key (key_is_last=0) or round key 10 (key_is_last=1); first byte in MSBs
key_is_last input   1    sampled with start; 1 = key_in is round key 10, skip expansion
busy        output  1    high whenever state != IDLE
out_valid   output  1    round key available on out_key
out_ready   input   1    consumer accepts out_key when out_valid && out_ready
out_key     output  128  current round key, words W0..W3 from MSB to LSB
out_round   output  4    round index of out_key, 10 down to 0
done        output  1    one-cycle pulse after round key 0 is accepted

Behaviour:
- Reset (asynchronous, rst_n=0): state=IDLE, key register=0, rnd=0, busy=0, out_valid=0, out_key=0, out_round=0, done=0. Reset asserted mid-operation aborts immediately with no further outputs.
- Rcon[r], r=1..10: 01,02,04,08,10,20,40,80,1b,36 in the top byte, remaining bytes 0. rnd=0 is never used as an Rcon index.
- Forward step fwd(K,r):
  - t = SubWord(RotWord(W3)) ^ Rcon[r]
  - W0' = W0 ^ t; W1' = W1 ^ W0'; W2' = W2 ^ W1'; W3' = W3 ^ W2'
- Inverse step inv(K,r), producing round key r-1 from round key r:
  - W3' = W3 ^ W2; W2' = W2 ^ W1; W1' = W1 ^ W0
  - W0' = W0 ^ SubWord(RotWord(W3')) ^ Rcon[r]
- Exactly 4 byte S-box instances are shared between both steps. A mux selects the S-box input: RotWord(W3) in EXPAND, RotWord(W3 ^ W2) in EMIT.
- State IDLE:
  - start=1 and key_is_last=0: key register <= key_in, rnd <= 0, go to EXPAND.
  - start=1 and key_is_last=1: key register <= key_in, rnd <= 10, go to EMIT.
  - Otherwise hold.
- State EXPAND, one step per cycle:
  - key register <= fwd(key register, rnd+1), rnd <= rnd+1.
  - When rnd+1 == 10, go to EMIT.
  - Occupies exactly 10 cycles. out_valid=0 throughout.
- State EMIT:
  - out_valid=1, out_key=key register, out_round=rnd; all three driven directly from registers.
  - On a handshake with rnd>0: key register <= inv(key register, rnd), rnd <= rnd-1, stay in EMIT. The next key is valid on the following cycle, so back-to-back acceptance gives 1 key per cycle.
  - On a handshake with rnd==0: go to IDLE and pulse done for 1 cycle.
  - With out_ready=0: out_key and out_round hold stable indefinitely.
- Latency:
  - key_is_last=0: start edge to first out_valid = 11 cycles.
  - key_is_last=1: start edge to first out_valid = 1 cycle.
  - Full drain with out_ready held at 1: 11 accepted keys over 11 consecutive cycles.
- Simultaneous and illegal events:
  - start while busy=1 is ignored, and key_in is not sampled.
  - start in the same cycle as the done pulse (state already IDLE) is accepted normally.
  - out_ready while out_valid=0 has no effect.
- busy=1 in EXPAND and EMIT. It falls in the cycle done is high.

Test Plan:
1. FIPS-197 key 2b7e151628aed2a6abf7158809cf4f3c, key_is_last=0, out_ready=1:
   - Required: first out_valid at cycle 11 with out_round=10, out_key=d014f9a8c9ee2589e13f0cc8b6630ca6.
   - Next cycle: round 9 = ac7766f319fadc2128d12941575c006e.
   - Round 1 = a0fafe1788542cb123a339392a6c7605; round 0 = original key, followed by a done pulse.
2. key_is_last=1 with key_in=d014f9a8c9ee2589e13f0cc8b6630ca6:
   - Required: out_valid after 1 cycle.
   - The 11 keys must match scenario 1 in the same order.
3. Backpressure: out_ready randomly low, 50% of cycles:
   - out_key and out_round stable while stalled.
   - Exactly 11 handshakes, sequence identical to scenario 1.
4. Second start pulsed during EXPAND and again during EMIT with a different key_in:
   - Ignored; output sequence unchanged.
   - A start coinciding with done begins a new run.
5. rst_n pulled low during EMIT at out_round=5:
   - All outputs 0 immediately, state IDLE.
   - A subsequent start reproduces scenario 1 exactly.
6. All-zero key:
   - Round 10 = b4ef5bcb3e92e21123e951cf6f8f188e.
   - Reverse walk ends at all-zero round 0.
